// File: rtl/bk_adder_pkg.sv
// -----------------------------------------------------------------------------
// bk_adder_pkg
//   Shared definitions for the Brent-Kung adder:
//     BK_WIDTH_DEFAULT - default operand width
//     gp_t             - (generate, propagate) pair carried through the prefix tree
//     clog2()          - ceil(log2(value)), used to size the tree levels
// -----------------------------------------------------------------------------
package bk_adder_pkg;

  localparam int BK_WIDTH_DEFAULT = 16;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int clog2(input int value);
    int result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/bk_gp_cell.sv
// -----------------------------------------------------------------------------
// bk_gp_cell
//   Brent-Kung prefix operator: (G,P)hi o (G,P)lo = (Ghi | Phi&Glo, Phi&Plo).
//   Ports:
//     hi - (G,P) of the more significant span
//     lo - (G,P) of the adjacent less significant span
//     o  - combined (G,P) covering both spans
// -----------------------------------------------------------------------------
module bk_gp_cell
  import bk_adder_pkg::*;
(
  input  gp_t hi,
  input  gp_t lo,
  output gp_t o
);

  assign o.g = hi.g | (hi.p & lo.g);
  assign o.p = hi.p & lo.p;

endmodule

// File: rtl/bk_adder.sv
// -----------------------------------------------------------------------------
// bk_adder
//   Unsigned WIDTH-bit Brent-Kung parallel-prefix adder with registered output.
//   s = {1'b0,a} + {1'b0,b}; s[WIDTH] is the carry-out. One pair per cycle.
//   Ports:
//     clk     - rising-edge clock
//     rst_n   - asynchronous active-low reset (clears s, out_vld, input stage)
//     in_vld  - a/b valid this cycle
//     a, b    - WIDTH-bit unsigned operands
//     out_vld - s holds the sum of a qualified pair
//     s       - WIDTH+1-bit sum; held when no qualified pair arrives
//   Build option:
//     BK_ADDER_IN_REG_EN - register a, b and in_vld before the tree
//                          (latency 2 instead of 1; ports and arithmetic unchanged)
//   WIDTH must be a power of two, >= 2.
// -----------------------------------------------------------------------------
module bk_adder
  import bk_adder_pkg::*;
#(
  parameter int WIDTH = BK_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_vld,
  output logic [WIDTH:0]   s
);

  localparam int LEVELS = clog2(WIDTH);
  // Stage 0 holds bitwise g/p, stages 1..LEVELS the up-sweep,
  // stages LEVELS+1..2*LEVELS-1 the down-sweep.
  localparam int STAGES = 2 * LEVELS;

  logic             op_vld;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

`ifdef BK_ADDER_IN_REG_EN
  // NOTE: state is written with non-blocking assignments and the reset sits in
  // the sensitivity list, so every register clears the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_vld <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
    end else begin
      op_vld <= in_vld;
      op_a   <= a;
      op_b   <= b;
    end
  end
`else
  assign op_vld = in_vld;
  assign op_a   = a;
  assign op_b   = b;
`endif

  gp_t              tree [STAGES][WIDTH];
  logic [WIDTH-1:0] p_bit;
  logic [WIDTH-1:0] g_fin;
  logic [WIDTH-1:0] p_fin;

  // Pre-processing: per-bit generate and propagate.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pre
    assign tree[0][i].g = op_a[i] & op_b[i];
    assign tree[0][i].p = op_a[i] ^ op_b[i];
    assign p_bit[i]     = op_a[i] ^ op_b[i];
  end

  // Up-sweep: at level l, every node whose index ends a 2^l block absorbs
  // the node 2^(l-1) below it.
  for (genvar l = 1; l <= LEVELS; l++) begin : g_up
    for (genvar i = 0; i < WIDTH; i++) begin : g_node
      if (((i + 1) % (1 << l)) == 0) begin : g_cell
        bk_gp_cell u_cell (
          .hi (tree[l-1][i]),
          .lo (tree[l-1][i-(1<<(l-1))]),
          .o  (tree[l][i])
        );
      end else begin : g_pass
        assign tree[l][i] = tree[l-1][i];
      end
    end
  end

  // Down-sweep: fills in the prefixes the up-sweep skipped. At each level the
  // node half a block above a completed block boundary absorbs that boundary.
  for (genvar d = 1; d < LEVELS; d++) begin : g_down
    localparam int STEP = 1 << (LEVELS - d);
    localparam int HALF = STEP / 2;
    for (genvar i = 0; i < WIDTH; i++) begin : g_node
      if ((i >= STEP) && (((i + 1) % STEP) == HALF)) begin : g_cell
        bk_gp_cell u_cell (
          .hi (tree[LEVELS+d-1][i]),
          .lo (tree[LEVELS+d-1][i-HALF]),
          .o  (tree[LEVELS+d][i])
        );
      end else begin : g_pass
        assign tree[LEVELS+d][i] = tree[LEVELS+d-1][i];
      end
    end
  end

  // After the down-sweep, g_fin[i] is the carry out of bit i.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fin_bits
    assign g_fin[i] = tree[STAGES-1][i].g;
    assign p_fin[i] = tree[STAGES-1][i].p;
  end

  // Group propagate over the full prefix is not needed for the sum.
  logic unused_p;
  assign unused_p = ^p_fin;

  // Post-processing: c_0 = 0, c_i = G[i-1:0]; s_i = p_i ^ c_i.
  logic [WIDTH-1:0] carry;
  logic [WIDTH:0]   sum;
  assign carry = {g_fin[WIDTH-2:0], 1'b0};
  assign sum   = {g_fin[WIDTH-1], p_bit ^ carry};

  // s only loads on a qualified pair, so it holds its last sum otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s       <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= op_vld;
      if (op_vld) begin
        s <= sum;
      end
    end
  end

endmodule

// File: tb/tb_bk_adder.sv
// -----------------------------------------------------------------------------
// tb_bk_adder
//   Self-checking bench for bk_adder (WIDTH = 16). A behavioural model tracks
//   the expected out_vld / s after every clock; table vectors and hand-written
//   sequences additionally compare against fixed constants.
//   Define BK_ADDER_IN_REG_EN for both RTL and bench to test the 2-cycle build.
// -----------------------------------------------------------------------------
module tb_bk_adder;

  localparam int W = 16;
`ifdef BK_ADDER_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_vld = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_vld;
  logic [W:0]   s;

  bk_adder #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .a       (a),
    .b       (b),
    .out_vld (out_vld),
    .s       (s)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of driven {vld, a+b} items delayed by LAT
  // clocks; s shows the most recent valid sum that has emerged.
  typedef struct {
    logic        vld;
    logic [W:0]  sum;
  } item_t;

  item_t      pend[$];
  logic [W:0] held_sum = '0;

  task automatic model_reset();
    pend.delete();
    held_sum = '0;
  endtask

  // Apply one pair for one clock, then compare outputs with the model.
  task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y);
    item_t it;
    logic  exp_vld;
    in_vld = v;
    a      = x;
    b      = y;
    it.vld = v;
    it.sum = {1'b0, x} + {1'b0, y};
    pend.push_back(it);
    @(posedge clk);
    #1;
    exp_vld = 1'b0;
    if (pend.size() == LAT) begin
      it      = pend.pop_front();
      exp_vld = it.vld;
      if (it.vld) held_sum = it.sum;
    end
    check("model_vld", 32'(out_vld), 32'(exp_vld));
    check("model_s", 32'(s), 32'(held_sum));
  endtask

  typedef struct {
    string       name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   sum;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [W:0] seq_s [3];
    logic       seq_v [3];
    logic [W-1:0] seq_a [3];
    logic [W-1:0] seq_b [3];

    vecs[0] = '{name: "max_plus_123", a: 16'd65535, b: 16'd123,   sum: 17'd65658};
    vecs[1] = '{name: "zero_zero",    a: 16'd0,     b: 16'd0,     sum: 17'd0};
    vecs[2] = '{name: "max_plus_one", a: 16'd65535, b: 16'd1,     sum: 17'd65536};
    vecs[3] = '{name: "max_plus_max", a: 16'd65535, b: 16'd65535, sum: 17'd131070};
    vecs[4] = '{name: "alt_bits",     a: 16'h5555,  b: 16'hAAAA,  sum: 17'd65535};

    // Reset state.
    #2;
    check("rst_vld", 32'(out_vld), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Boundary and carry-out vectors against fixed constants.
    foreach (vecs[k]) begin
      drive(1'b1, vecs[k].a, vecs[k].b);
      for (int j = 1; j < LAT; j++) drive(1'b0, 16'hFFFF, 16'hFFFF);
      check({vecs[k].name, "_vld"}, 32'(out_vld), 32'd1);
      check({vecs[k].name, "_s"}, 32'(s), 32'(vecs[k].sum));
      check({vecs[k].name, "_cout"}, 32'(s[W]), 32'(vecs[k].sum[W]));
    end

    // in_vld toggling 1,0,1: outputs 3 (vld), 3 held (no vld), 7 (vld).
    seq_a = '{16'd1, 16'd7, 16'd3};
    seq_b = '{16'd2, 16'd7, 16'd4};
    seq_v = '{1'b1, 1'b0, 1'b1};
    seq_s = '{17'd3, 17'd3, 17'd7};
    for (int j = 0; j < 3 + LAT - 1; j++) begin
      if (j < 3) drive(seq_v[j], seq_a[j], seq_b[j]);
      else       drive(1'b0, 16'd0, 16'd0);
      if (j >= LAT - 1) begin
        check("toggle_vld", 32'(out_vld), 32'(seq_v[j-LAT+1]));
        check("toggle_s", 32'(s), 32'(seq_s[j-LAT+1]));
      end
    end

    // Exhaustive 8-bit operands, back-to-back.
    for (int x = 0; x < 256; x++) begin
      for (int y = 0; y < 256; y++) begin
        drive(1'b1, W'(x), W'(y));
      end
    end

    // Randomized operands and valid pattern.
    for (int j = 0; j < 2000; j++) begin
      drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom));
    end

    // Asynchronous reset mid-stream: outputs clear without a clock edge and
    // in-flight pairs are lost.
    drive(1'b1, 16'd1000, 16'd2000);
    drive(1'b1, 16'd40000, 16'd30000);
    in_vld = 1'b1;
    a      = 16'd5;
    b      = 16'd6;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_vld", 32'(out_vld), 32'd0);
    check("async_rst_s", 32'(s), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_vld", 32'(out_vld), 32'd0);
    check("rst_hold_s", 32'(s), 32'd0);
    rst_n = 1'b1;
    model_reset();
    for (int j = 0; j < LAT; j++) drive(1'b0, 16'd9, 16'd9);
    check("post_rst_s", 32'(s), 32'd0);
    drive(1'b1, 16'd100, 16'd23);
    for (int j = 1; j < LAT; j++) drive(1'b0, 16'd0, 16'd0);
    check("post_rst_sum", 32'(s), 32'd123);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
